// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF fetch and MEM load/store, one transaction in flight.
// Define ARB_PERF_CNT_EN to add saturating stall-cycle counters perf_if_stall/perf_d_stall.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_flush,
    output logic [DW-1:0]   if_rdata,
    output logic            if_valid,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_valid,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            stall_if,
`ifdef ARB_PERF_CNT_EN
    output logic            stall_mem,
    output logic [31:0]     perf_if_stall,
    output logic [31:0]     perf_d_stall
`else
    output logic            stall_mem
`endif
);
    localparam int BW = DW / 8;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e          state_q, state_d;
    logic            gnt_if_q, gnt_if_d;
    logic            drop_q, drop_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic            mem_we_q, mem_we_d;
    logic [BW-1:0]   mem_be_q, mem_be_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            pick_if;

    // Data wins a tie unless fetch has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        pick_if = if_req && (!d_req || streak_q == SW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_if_q    <= 1'b0;
            drop_q      <= 1'b0;
            streak_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_if_q    <= gnt_if_d;
            drop_q      <= drop_d;
            streak_q    <= streak_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_if_d    = gnt_if_q;
        drop_d      = drop_q;
        streak_d    = streak_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d  = ISSUE;
                    gnt_if_d = pick_if;
                    drop_d   = 1'b0;
                    if (pick_if) begin
                        mem_we_d    = 1'b0;
                        mem_be_d    = '1;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        streak_d    = '0;
                    end else begin
                        mem_we_d    = d_we;
                        mem_be_d    = d_we ? d_be : '1;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_we ? d_wdata : '0;
                        if (if_req) begin
                            streak_d = streak_q + SW'(1);
                        end
                    end
                end
            end
            ISSUE: begin
                if (gnt_if_q && if_flush) begin
                    drop_d = 1'b1;
                end
                if (mem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (gnt_if_q && if_flush) begin
                    drop_d = 1'b1;
                end
                if (mem_rvalid) begin
                    state_d = DONE;
                    if (gnt_if_q) begin
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            DONE: begin
                drop_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A flush raised in DONE still kills the pulse, hence the combinational term.
    assign if_valid  = (state_q == DONE) && gnt_if_q && !drop_q && !if_flush;
    assign d_valid   = (state_q == DONE) && !gnt_if_q;
    assign mem_req   = (state_q == ISSUE);
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req && !if_valid;
    assign stall_mem = d_req && !d_valid;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_q, perf_d_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_q <= '0;
            perf_d_q  <= '0;
        end else begin
            if (stall_if && perf_if_q != '1) begin
                perf_if_q <= perf_if_q + 32'd1;
            end
            if (stall_mem && perf_d_q != '1) begin
                perf_d_q <= perf_d_q + 32'd1;
            end
        end
    end

    assign perf_if_stall = perf_if_q;
    assign perf_d_stall  = perf_d_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural single-port memory.
// Builds with or without ARB_PERF_CNT_EN.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_flush = 1'b0;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [BW-1:0] d_be = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          mem_req;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall_if;
    logic          stall_mem;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   perf_if_stall;
    logic [31:0]   perf_d_stall;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_if(stall_if),
`ifdef ARB_PERF_CNT_EN
        .stall_mem(stall_mem),
        .perf_if_stall(perf_if_stall),
        .perf_d_stall(perf_d_stall)
`else
        .stall_mem(stall_mem)
`endif
    );

    typedef struct {
        bit          is_if;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void expect_r(input bit is_if, input bit chk, input logic [31:0] d);
        exp_t e;
        e.is_if = is_if;
        e.chk   = chk;
        e.data  = d;
        sbq.push_back(e);
    endfunction

    // Monitor: every completion pulse must match the next expected response.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset && (if_valid || d_valid)) begin
            check("valid_exclusive", 32'(if_valid & d_valid), 32'd0);
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got if=%0b d=%0b, expected none", if_valid, d_valid);
            end else begin
                e = sbq.pop_front();
                check("resp_kind", 32'(if_valid), 32'(e.is_if));
                if (e.chk) begin
                    check("resp_data", if_valid ? if_rdata : d_rdata, e.data);
                end
            end
        end
    end

    // Memory model: accepts after ready_delay stalled cycles, completes one cycle later.
    logic [31:0] mem [logic [31:0]];
    int          ready_delay = 0;
    int          wcnt = 0;
    bit          acc = 0;
    logic [31:0] rd = '0;
    logic [31:0] wtmp;
    int          req_cycles = 0;
    int          last_req_cycles = 0;
    bit          cmd_chk = 0;
    logic        exp_we = 1'b0;
    logic [3:0]  exp_be = '0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;

    initial forever begin
        @(posedge clk);
        #2;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        if (reset) begin
            acc        = 0;
            wcnt       = 0;
            req_cycles = 0;
        end else if (acc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
            acc        = 0;
        end else if (mem_req) begin
            req_cycles++;
            if (cmd_chk) begin
                check("cmd_we", 32'(mem_we), 32'(exp_we));
                check("cmd_be", 32'(mem_be), 32'(exp_be));
                check("cmd_addr", mem_addr, exp_addr);
                if (exp_we) begin
                    check("cmd_wdata", mem_wdata, exp_wdata);
                end
            end
            if (wcnt < ready_delay) begin
                wcnt++;
            end else begin
                mem_ready       = 1'b1;
                wcnt            = 0;
                acc             = 1;
                last_req_cycles = req_cycles;
                req_cycles      = 0;
                wtmp = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                if (mem_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[b]) wtmp[8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                    mem[mem_addr] = wtmp;
                    rd = 32'h0;
                end else begin
                    rd = wtmp;
                end
            end
        end
    end

    int seen_if = 0;
    int seen_d = 0;
    initial forever begin
        @(negedge clk);
        if (!reset && stall_if) seen_if++;
        if (!reset && stall_mem) seen_d++;
    end

    task automatic wait_valid(input bit is_if, output int cyc, output int stl);
        cyc = 0;
        stl = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (is_if ? if_valid : d_valid) begin
                check("stall_low_at_valid", 32'(is_if ? stall_if : stall_mem), 32'd0);
                return;
            end
            if (is_if ? stall_if : stall_mem) stl++;
        end
        tests++;
        fails++;
        $display("FAIL valid_timeout: got no valid in 200 cycles, expected one (is_if=%0b)", is_if);
        cyc = -1;
    endtask

    task automatic wait_accept(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_ready) return;
        end
        tests++;
        fails++;
        $display("FAIL %s: got no mem_ready in 50 cycles, expected acceptance", name);
    endtask

    // Drivers are entered at posedge+1 and leave req low at posedge+1 after the pulse,
    // so back-to-back calls keep req high across the DONE->IDLE edge.
    task automatic fetch(input logic [31:0] a, output int cyc, output int stl);
        if_req  = 1'b1;
        if_addr = a;
        wait_valid(1'b1, cyc, stl);
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic dop(input bit we, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd, output int cyc, output int stl);
        d_req   = 1'b1;
        d_we    = we;
        d_be    = be;
        d_addr  = a;
        d_wdata = wd;
        wait_valid(1'b0, cyc, stl);
        @(posedge clk);
        #1;
        d_req = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        int c, s, c2, s2;
`ifdef ARB_PERF_CNT_EN
        logic [31:0] p_if0, p_d0;
        int n_if0, n_d0;
`endif
        mem[32'h100]  = 32'h00A00093;
        mem[32'h104]  = 32'hBAD0BAD0;
        mem[32'h200]  = 32'h00B00113;
        mem[32'h400]  = 32'h00C00193;
        mem[32'h2000] = 32'h11223344;
        mem[32'h3000] = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) mem[32'h1000 + 4 * i] = 32'hD0000000 + i;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_d_valid", 32'(d_valid), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Lone fetch, minimum latency
        @(posedge clk);
        #1;
        cmd_chk = 1; exp_we = 1'b0; exp_be = 4'hF; exp_addr = 32'h100;
        expect_r(1'b1, 1'b1, 32'h00A00093);
        fetch(32'h100, c, s);
        cmd_chk = 0;
        check("t1_latency", c, 4);
        check("t1_stall_if_cycles", s, 3);
        check("t1_mem_req_cycles", last_req_cycles, 1);

        // Four data grants, then the starved fetch, then the last load
        for (int i = 0; i < 4; i++) expect_r(1'b0, 1'b1, 32'hD0000000 + i);
        expect_r(1'b1, 1'b1, 32'h00C00193);
        expect_r(1'b0, 1'b1, 32'hD0000004);
        fork
            begin
                int fc, fs;
                for (int i = 0; i < 5; i++) dop(1'b0, 4'hF, 32'h1000 + 4 * i, 32'h0, fc, fs);
            end
            fetch(32'h400, c2, s2);
        join
        check("t2_fetch_wait", c2, 20);

        // Store with a slow memory, then read back the merged word
        ready_delay = 3;
        cmd_chk = 1; exp_we = 1'b1; exp_be = 4'b0011;
        exp_addr = 32'h2000; exp_wdata = 32'hDEADBEEF;
        expect_r(1'b0, 1'b0, 32'h0);
        dop(1'b1, 4'b0011, 32'h2000, 32'hDEADBEEF, c, s);
        cmd_chk = 0;
        ready_delay = 0;
        check("t3_mem_req_cycles", last_req_cycles, 4);
        check("t3_latency", c, 7);
        expect_r(1'b0, 1'b1, 32'h1122BEEF);
        dop(1'b0, 4'hF, 32'h2000, 32'h0, c, s);

        // Flush during WAIT drops the fetch; redirected fetch follows
        expect_r(1'b1, 1'b1, 32'h00B00113);
        if_req = 1'b1;
        if_addr = 32'h104;
        wait_accept("t4_accept");
        @(posedge clk);
        #1;
        if_flush = 1'b1;
        if_addr = 32'h200;
        @(posedge clk);
        #1;
        if_flush = 1'b0;
        wait_valid(1'b1, c, s);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        check("t4_refetch_latency", c, 5);

        // Reset in WAIT abandons the load
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h3000;
        wait_accept("t5_accept");
        @(posedge clk);
        #1;
        reset = 1'b1;
        d_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_mem_req", 32'(mem_req), 32'd0);
        check("t5_mem_addr", mem_addr, 32'd0);
        check("t5_d_valid", 32'(d_valid), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        expect_r(1'b0, 1'b1, 32'hCAFEF00D);
        dop(1'b0, 4'hF, 32'h3000, 32'h0, c, s);
        check("t5_fresh_latency", c, 4);

`ifdef ARB_PERF_CNT_EN
        // Fetch held behind a slow load
        repeat (2) @(posedge clk);
        #1;
        p_if0 = perf_if_stall; p_d0 = perf_d_stall;
        n_if0 = seen_if; n_d0 = seen_d;
        ready_delay = 3;
        expect_r(1'b0, 1'b1, 32'hD0000000);
        expect_r(1'b1, 1'b1, 32'h00A00093);
        fork
            dop(1'b0, 4'hF, 32'h1000, 32'h0, c, s);
            fetch(32'h100, c2, s2);
        join
        ready_delay = 0;
        repeat (2) @(posedge clk);
        #1;
        check("t6_perf_if_delta", perf_if_stall - p_if0, 32'd13);
        check("t6_perf_d_delta", perf_d_stall - p_d0, 32'd6);
        check("t6_perf_if_vs_seen", perf_if_stall - p_if0, 32'(seen_if - n_if0));
        check("t6_perf_d_vs_seen", perf_d_stall - p_d0, 32'(seen_d - n_d0));
`endif

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
